// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared types and constants for the countdown timer
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Codes 10 and 11 fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter_byte_merge.sv
// rtl/timer_counter_byte_merge.sv - lane-masked merge of a store into an existing word
module byte_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  byteen_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (byteen_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with one-shot/auto-reload and irq
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_pend_q;
    state_e      state_q;

    logic [31:0] ctrl_d;
    logic [31:0] preset_d;
    logic [1:0]  offset;
    logic        wr_any;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        reload_mode;
    logic        addr_unused;
    logic        ctrl_d_unused;

    assign offset      = addr[3:2];
    assign wr_any      = |byteen;
    assign ctrl_wr     = wr_any && (offset == OFF_CTRL);
    assign preset_wr   = wr_any && (offset == OFF_PRESET);
    assign reload_mode = is_reload(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);

    assign addr_unused   = ^{addr[31:4], addr[1:0]};
    assign ctrl_d_unused = ^ctrl_d[31:4];

    byte_merge u_ctrl_merge (
        .old_i    ({28'd0, ctrl_q}),
        .new_i    (wdata),
        .byteen_i (byteen),
        .merged_o (ctrl_d)
    );

    byte_merge u_preset_merge (
        .old_i    (preset_q),
        .new_i    (wdata),
        .byteen_i (byteen),
        .merged_o (preset_d)
    );

    // Statement order matters: FSM irq set overrides the CTRL-write clear,
    // and a CTRL write overrides the one-shot EN clear in INT.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_pend_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            if (ctrl_wr && !reload_mode) begin
                irq_pend_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ctrl_q[CTRL_EN]) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_q <= preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[CTRL_EN]) begin
                        state_q <= ST_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q    <= 32'd0;
                        irq_pend_q <= 1'b1;
                        state_q    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (reload_mode) begin
                        irq_pend_q <= 1'b0;
                        state_q    <= ST_LOAD;
                    end else begin
                        ctrl_q[CTRL_EN] <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (ctrl_wr) begin
                ctrl_q <= ctrl_d[3:0];
            end
            if (preset_wr) begin
                preset_q <= preset_d;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (offset)
            OFF_CTRL:   rdata = {28'd0, ctrl_q};
            OFF_PRESET: rdata = preset_q;
            OFF_COUNT:  rdata = count_q;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_pend_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int passes = 0;

    timer_counter dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [1:0] off);
        addr = ($urandom & 32'hFFFF_FFF3) | {28'd0, off, 2'b00};
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
        set_addr(off);
        wdata  = d;
        byteen = be;
        tick();
        byteen = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] v);
        set_addr(off);
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        byteen = 4'b0000;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int o = 0; o < 4; o++) begin
            rd(o[1:0], v);
            checks++;
            if (v !== 32'd0) $display("FAIL reset_read[%0d]: got %h expected 0", o, v);
            else passes++;
        end
        checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
        else passes++;
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd5, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);
        tick(); tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd5) $display("FAIL oneshot_count_e2: got %0d expected 5", v);
        else passes++;
        repeat (4) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd1) $display("FAIL oneshot_count_e6: got %0d expected 1", v);
        else passes++;
        checks++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_e6: got %b expected 0", irq);
        else passes++;
        tick();
        checks++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_e7: got %b expected 1", irq);
        else passes++;
        tick();
        checks++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_hold: got %b expected 1", irq);
        else passes++;
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) $display("FAIL oneshot_ctrl_after: got %h expected 8", v);
        else passes++;
        bus_write(2'd0, 32'h8, 4'hF);
        checks++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
        else passes++;
    endtask

    task automatic test_preset_zero();
        do_reset();
        bus_write(2'd1, 32'd0, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);
        tick(); tick();
        checks++;
        if (irq !== 1'b0) $display("FAIL preset0_irq_e2: got %b expected 0", irq);
        else passes++;
        tick();
        checks++;
        if (irq !== 1'b1) $display("FAIL preset0_irq_e3: got %b expected 1", irq);
        else passes++;
    endtask

    task automatic test_reload();
        logic [31:0] v;
        logic        exp;
        do_reset();
        bus_write(2'd1, 32'd3, 4'hF);
        bus_write(2'd0, 32'hB, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k >= 5) && ((k - 5) % 5 == 0);
            checks++;
            if (irq !== exp) $display("FAIL reload_irq k=%0d: got %b expected %b", k, irq, exp);
            else passes++;
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'hB) $display("FAIL reload_ctrl: got %h expected b", v);
        else passes++;
    endtask

    task automatic test_byte_mask();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'hAABB_CCDD, 4'hF);
        set_addr(2'd1);
        wdata  = 32'h1122_3344;
        byteen = 4'b0101;
        #1;
        checks++;
        if (rdata !== 32'hAABB_CCDD) $display("FAIL read_during_write: got %h expected aabbccdd", rdata);
        else passes++;
        tick();
        byteen = 4'b0000;
        rd(2'd1, v);
        checks++;
        if (v !== 32'hAA22_CC44) $display("FAIL byte_mask_preset: got %h expected aa22cc44", v);
        else passes++;
        bus_write(2'd2, 32'hFFFF_FFFF, 4'hF);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) $display("FAIL count_readonly: got %h expected 0", v);
        else passes++;
        bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        rd(2'd3, v);
        checks++;
        if (v !== 32'd0) $display("FAIL offset3_read: got %h expected 0", v);
        else passes++;
        bus_write(2'd0, 32'hFFFF_FFF0, 4'hF);
        rd(2'd0, v);
        checks++;
        if (v !== 32'd0) $display("FAIL ctrl_upper_bits: got %h expected 0", v);
        else passes++;
    endtask

    task automatic test_disable();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd20, 4'hF);
        bus_write(2'd0, 32'h1, 4'hF);
        repeat (12) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd10) $display("FAIL disable_count10: got %0d expected 10", v);
        else passes++;
        bus_write(2'd0, 32'h0, 4'hF);
        repeat (3) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd9) $display("FAIL disable_freeze: got %0d expected 9", v);
        else passes++;
        bus_write(2'd0, 32'h1, 4'h1);
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd9) $display("FAIL reenable_e1: got %0d expected 9", v);
        else passes++;
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd20) $display("FAIL reenable_reload: got %0d expected 20", v);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        do_reset();
        bus_write(2'd1, 32'd3, 4'hF);
        bus_write(2'd0, 32'hB, 4'hF);
        repeat (5) tick();
        checks++;
        if (irq !== 1'b1) $display("FAIL resetmid_irq_before: got %b expected 1", irq);
        else passes++;
        do_reset();
        checks++;
        if (irq !== 1'b0) $display("FAIL resetmid_irq_after: got %b expected 0", irq);
        else passes++;
        for (int o = 0; o < 3; o++) begin
            rd(o[1:0], v);
            checks++;
            if (v !== 32'd0) $display("FAIL resetmid_read[%0d]: got %h expected 0", o, v);
            else passes++;
        end
    endtask

    // Reference: edges k after the enabling write; period = max(N,1)+2.
    task automatic test_random();
        logic [31:0] v;
        logic [31:0] n;
        logic [1:0]  mode;
        logic        im;
        logic        reload;
        logic        pend;
        logic [31:0] exp_cnt;
        logic [3:0]  ctrl_val;
        int          nn, per, p, total;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n        = $urandom_range(0, 12);
            mode     = 2'($urandom_range(0, 3));
            im       = 1'($urandom_range(0, 1));
            reload   = (mode == 2'b01);
            ctrl_val = {im, mode, 1'b1};
            nn       = (n == 0) ? 1 : int'(n);
            per      = nn + 2;
            total    = 3 * per + 2;
            bus_write(2'd1, n, 4'hF);
            bus_write(2'd0, {28'd0, ctrl_val}, 4'hF);
            for (int k = 1; k <= total; k++) begin
                tick();
                if (reload) begin
                    pend = (k >= per) && ((k - per) % per == 0);
                    p    = (k - 2) % per;
                end else begin
                    pend = (k >= per);
                    p    = k - 2;
                end
                if (k < 2) exp_cnt = 32'd0;
                else exp_cnt = (p < nn) ? n - 32'(p) : 32'd0;
                checks++;
                if (irq !== (pend & im))
                    $display("FAIL rand_irq it=%0d k=%0d: got %b expected %b", it, k, irq, pend & im);
                else passes++;
                rd(2'd2, v);
                checks++;
                if (v !== exp_cnt)
                    $display("FAIL rand_count it=%0d k=%0d: got %0d expected %0d", it, k, v, exp_cnt);
                else passes++;
            end
            rd(2'd0, v);
            checks++;
            if (v !== {28'd0, reload ? ctrl_val : (ctrl_val & 4'hE)})
                $display("FAIL rand_ctrl it=%0d: got %h expected %h", it, v,
                         {28'd0, reload ? ctrl_val : (ctrl_val & 4'hE)});
            else passes++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        addr   = 32'd0;
        byteen = 4'b0000;
        wdata  = 32'd0;
        tick();
        test_reset();
        test_oneshot();
        test_preset_zero();
        test_reload();
        test_byte_mask();
        test_disable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
